imm_share_arbiter: RTL
======================

Name: imm_share_arbiter

Overview:
Shares one immediate-generation datapath between two requesters: req0 (decode stage) and req1 (fetch-stage predecoder that feeds the branch predictor's target path). Requests are arbitrated round-robin, and the immediate and PC-relative target are computed in one pass. Results are registered into a single output slot with valid/ready backpressure. The block sits between fetch/decode and the branch-target/redirect logic.

Parameters:
TAG_W, 4, width of the requester-supplied tag returned with each result.
CNT_W, 8, width of the saturating contention counter.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has an instruction
req0_ready  output  1  requester 0 accepted this cycle
req0_instr  input  32  requester 0 instruction word
req0_pc  input  32  requester 0 instruction PC
req0_tag  input  TAG_W  requester 0 tag
req1_valid  input  1  requester 1 has an instruction
req1_ready  output  1  requester 1 accepted this cycle
req1_instr  input  32  requester 1 instruction word
req1_pc  input  32  requester 1 instruction PC
req1_tag  input  TAG_W  requester 1 tag
out_valid  output  1  result slot occupied
out_ready  input  1  consumer takes result
out_src  output  1  requester id of result (0/1)
out_tag  output  TAG_W  tag of result
out_imm  output  32  sign-extended immediate
out_target  output  32  pc + out_imm, modulo 2^32
out_no_imm  output  1  opcode carries no immediate (R-type/unknown); out_imm=0
contention_cnt  output  CNT_W  saturating count of cycles with both requests valid

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. Port names are clk and rst.
- Reset values:
  - out_valid=0; out_src, out_tag, out_imm, out_target, out_no_imm=0.
  - contention_cnt=0.
  - last_grant=1, so req0 wins the first contention.
- accept_en = !out_valid || out_ready. This gives a one-slot pipeline with full throughput under continuous out_ready.
- Grant selection (combinational):
  - Only one request valid: grant it.
  - Both valid: grant the requester not equal to last_grant.
  - reqN_ready = accept_en && reqN_valid && (grant==N). At most one ready per cycle.
- Accept (grant valid && accept_en), at the clock edge:
  - Register the result fields.
  - out_valid<=1.
  - last_grant<=grant.
- Pop without accept (out_valid && out_ready && no request): out_valid<=0. Output data holds its last value.
- Pop and accept in the same cycle: the new result replaces the old. out_valid stays 1.
- Latency: accept in cycle N -> result visible from cycle N+1.
- Hold rule: while out_valid && !out_ready, all out_* are stable. Requesters hold their own valid/data until ready (standard valid/ready contract).
- Immediate decode by opcode instr[6:0]:
  - I-type (0000011, 0010011, 1100111 jalr): sign-extend instr[31:20].
  - S-type (0100011): {instr[31:25], instr[11:7]}, sign-extended.
  - B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}, sign-extended.
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}.
  - J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}, sign-extended.
  - All other opcodes: imm=0, out_no_imm=1.
- out_target = pc + imm, computed on the granted request only. Wraps modulo 2^32. For jalr the value is informational only; the register base is not known here.
- contention_cnt: increments in every cycle where req0_valid && req1_valid, independent of accept_en. Saturates at 2^CNT_W-1.
- rst asserted mid-operation: any held result is dropped immediately and all state returns to reset values. A request presented during rst gets ready=0.

Decomposition:
- Shared package holds:
  - Opcode constants: OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL.
  - Requester-id constants: SRC_DEC=0, SRC_PRE=1.
- One sub-module, imm_decode: purely combinational, instr -> {imm, no_imm}. It is instantiated once after the grant mux. This shares one decoder rather than two.
- Arbitration, output register and counter stay in the top module.

Test Plan:
- Single imm request: req0 addi 0x00500093, pc=0x0 -> next cycle: out_valid=1, out_imm=0x5, out_target=0x5, out_src=0, out_no_imm=0.
- Branch: req1 beq 0xFE000EE3, pc=0x100, tag=3 -> out_imm=0xFFFFFFFC, out_target=0xFC, out_src=1, out_tag=3.
- Contention:
  - Stimulus: both requesters valid continuously after reset, out_ready=1; req0 jal 0x008000EF, req1 lui 0x12345037.
  - Expected grant order: 0,1,0,1.
  - Expected results: jal gives out_imm=0x8; lui gives out_imm=0x12345000.
  - contention_cnt equals the number of both-valid cycles.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_* stable, both readys 0; on out_ready=1, the pending request is accepted in the same cycle.
- Non-immediate and wrap: R-type 0x002081B3 -> out_no_imm=1, out_imm=0. Wrap case: pc=0xFFFFFFFC with jal +8 -> out_target=0x4.
- Reset mid-hold: assert rst while out_valid=1 -> out_valid=0 and contention_cnt=0 immediately. Next contention after release grants req0.

Source files
------------

// File: rtl/imm_share_arbiter_pkg.sv
// Shared constants for the immediate-generation arbiter: RISC-V opcodes and requester ids.
package imm_share_arbiter_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic SRC_DEC = 1'b0;
    localparam logic SRC_PRE = 1'b1;

endpackage

// File: rtl/imm_share_arbiter_if.sv
// Two requester ports plus the single result slot of the shared immediate generator.
interface imm_share_arbiter_if #(parameter int TAG_W = 4);

    logic             req0_valid;
    logic             req0_ready;
    logic [31:0]      req0_instr;
    logic [31:0]      req0_pc;
    logic [TAG_W-1:0] req0_tag;
    logic             req1_valid;
    logic             req1_ready;
    logic [31:0]      req1_instr;
    logic [31:0]      req1_pc;
    logic [TAG_W-1:0] req1_tag;
    logic             out_valid;
    logic             out_ready;
    logic             out_src;
    logic [TAG_W-1:0] out_tag;
    logic [31:0]      out_imm;
    logic [31:0]      out_target;
    logic             out_no_imm;

    modport master (
        output req0_valid, req0_instr, req0_pc, req0_tag,
        output req1_valid, req1_instr, req1_pc, req1_tag,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_src, out_tag, out_imm, out_target, out_no_imm
    );

    modport slave (
        input  req0_valid, req0_instr, req0_pc, req0_tag,
        input  req1_valid, req1_instr, req1_pc, req1_tag,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_src, out_tag, out_imm, out_target, out_no_imm
    );

endinterface

// File: rtl/imm_share_arbiter_imm_decode.sv
// Combinational RV32 immediate extractor; opcodes without an immediate flag no_imm.
module imm_decode
    import imm_share_arbiter_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm,
    output logic        no_imm
);

    always_comb begin
        imm    = '0;
        no_imm = 1'b0;
        case (instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR:
                imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {instr[31:12], 12'b0};
            OP_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                no_imm = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_share_arbiter.sv
// Round-robin share of one immediate/target datapath between decode and predecode,
// with a single registered result slot under valid/ready backpressure.
module imm_share_arbiter
    import imm_share_arbiter_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    imm_share_arbiter_if.slave   bus,
    output logic [CNT_W-1:0]     contention_cnt
);

    logic             out_valid_q, out_valid_d;
    logic             out_src_q, out_src_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [31:0]      out_imm_q, out_imm_d;
    logic [31:0]      out_target_q, out_target_d;
    logic             out_no_imm_q, out_no_imm_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept_en, any_req, grant, accept;
    logic [31:0]      instr_sel, pc_sel, imm_w;
    logic [TAG_W-1:0] tag_sel;
    logic             no_imm_w;

    // Single decoder sits after the grant mux so both requesters share it.
    imm_decode u_dec (
        .instr  (instr_sel),
        .imm    (imm_w),
        .no_imm (no_imm_w)
    );

    always_comb begin
        accept_en = !out_valid_q || bus.out_ready;
        any_req   = bus.req0_valid || bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) grant = ~last_grant_q;
        else                                  grant = bus.req1_valid ? SRC_PRE : SRC_DEC;
        accept    = any_req && accept_en && !rst;

        instr_sel = (grant == SRC_PRE) ? bus.req1_instr : bus.req0_instr;
        pc_sel    = (grant == SRC_PRE) ? bus.req1_pc    : bus.req0_pc;
        tag_sel   = (grant == SRC_PRE) ? bus.req1_tag   : bus.req0_tag;

        bus.req0_ready = accept && bus.req0_valid && (grant == SRC_DEC);
        bus.req1_ready = accept && bus.req1_valid && (grant == SRC_PRE);

        out_valid_d  = out_valid_q;
        out_src_d    = out_src_q;
        out_tag_d    = out_tag_q;
        out_imm_d    = out_imm_q;
        out_target_d = out_target_q;
        out_no_imm_d = out_no_imm_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_src_d    = grant;
            out_tag_d    = tag_sel;
            out_imm_d    = imm_w;
            out_target_d = pc_sel + imm_w;
            out_no_imm_d = no_imm_w;
            last_grant_d = grant;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        cnt_d = cnt_q;
        if (bus.req0_valid && bus.req1_valid && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_src_q    <= 1'b0;
            out_tag_q    <= '0;
            out_imm_q    <= '0;
            out_target_q <= '0;
            out_no_imm_q <= 1'b0;
            last_grant_q <= SRC_PRE;
            cnt_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_src_q    <= out_src_d;
            out_tag_q    <= out_tag_d;
            out_imm_q    <= out_imm_d;
            out_target_q <= out_target_d;
            out_no_imm_q <= out_no_imm_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_src    = out_src_q;
    assign bus.out_tag    = out_tag_q;
    assign bus.out_imm    = out_imm_q;
    assign bus.out_target = out_target_q;
    assign bus.out_no_imm = out_no_imm_q;
    assign contention_cnt = cnt_q;

endmodule
